sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Synchronous single-clock FIFO. It is the parametrised successor to the team's basic 8x8 FIFO. Adds:
- arbitrary (non-power-of-two) depth
- occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- optional first-word-fall-through read mode

Used as the general buffering element between producer/consumer stages in the datapath.

Parameters:
DEPTH, 8, number of entries; any integer >= 2, power of two not required
DATA_WIDTH, 8, bits per entry
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
clr  in  1  synchronous flush
wren  in  1  write request
i_data  in  DATA_WIDTH  write data
rden  in  1  read request
o_data  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  CW  occupancy, CW = $clog2(DEPTH+1)
overflow  out  1  sticky: write was rejected
underflow  out  1  sticky: read was rejected

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: rd_ptr=0, wr_ptr=0, count=0, o_data=0, empty=1, full=0, almost_empty=1, almost_full=0 (almost_full=1 only if AF_THRESH==0, which is illegal). overflow=0, underflow=0. Memory contents are not reset.
- rst asserted mid-operation discards all queued data at that edge; rst has priority over clr, wren and rden.
- Acceptance rules:
  - rd_acc = rden && !empty
  - wr_acc = wren && (!full || rd_acc)
  - Full with both requests: read and write both accepted, count unchanged.
  - Empty with both requests: write accepted, read rejected (non-FWFT mode).
- Write: on wr_acc, mem[wr_ptr] <= i_data and wr_ptr advances.
- Read: on rd_acc, o_data <= mem[rd_ptr] (1-cycle read latency) and rd_ptr advances. o_data holds its value otherwise.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- count: next = count + wr_acc - rd_acc. Never exceeds DEPTH and never goes below 0.
- All status flags are registered and derived from next count, so they are valid in the same cycle as the count they describe.
- overflow is set when wren && !wr_acc. underflow is set when rden && !rd_acc. Both hold until rst or clr.
- clr: at the edge, pointers and count go to 0, flags return to their reset values, and overflow/underflow clear. o_data holds its value.
  - wren/rden in the same cycle as clr are ignored and do not set error flags.
- Back-to-back full-rate streaming (wren=rden=1 every cycle, non-empty) sustains one transfer per cycle indefinitely.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - o_data = mem[rd_ptr] combinationally whenever !empty; o_data = 0 when empty.
  - rden acts as a pop/acknowledge of the currently shown word.
  - A word written into an empty FIFO appears on o_data the cycle after the write edge, when empty falls.
  - Simultaneous wren+rden while empty: write accepted, read rejected, underflow set.
- Undefined: standard registered 1-cycle read latency as described in Behaviour.
- Flags, count and error rules are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - function fifo_cw(depth) returning $clog2(depth+1)
  - typedef of the error-flag pair struct {overflow, underflow}
- One natural sub-module, fifo_wrap_ctr:
  - parameter MAX
  - inputs clk, rst, clr, inc
  - output ptr
  - wraps MAX-1 -> 0
  - instantiated twice, for rd_ptr and wr_ptr.

Test Plan:
- DEPTH=5, write 0x11..0x55 with no reads -> full=1 and count=5 after the 5th edge; almost_full=1 from count=3. A 6th write sets overflow=1, count stays 5, and data is unchanged.
- Continue from the full state, read 5 times -> o_data sequence 0x11,0x22,0x33,0x44,0x55, each one cycle after its rden. empty=1 after the 5th read. A 6th rden sets underflow=1 and o_data holds 0x55.
- DEPTH=5, stream 12 words with wren=rden=1 after 2 preload writes -> output order preserved across pointer wrap (ptr 4->0), count stays 2, no error flags set.
- Full FIFO with wren=rden=1 -> both accepted, count stays DEPTH, overflow stays 0. Empty FIFO with wren=rden=1 -> count=1, underflow=1.
- 3 entries queued, overflow set, assert clr together with wren -> count=0, empty=1, overflow=0, and the written word is dropped. Assert rst mid-stream -> all outputs at reset values next cycle.
- SYNC_FIFO_FWFT_EN defined, write 0xA5 into empty -> o_data=0xA5 and empty=0 one cycle later without rden. rden for one cycle -> empty=1 and o_data=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helper and error-flag type for sync_fifo_param
package sync_fifo_pkg;
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_t;
endpackage

// File: rtl/fifo_wrap_ctr.sv
// fifo_wrap_ctr: pointer counter that wraps MAX-1 -> 0 by compare, cleared by rst or clr
module fifo_wrap_ctr
  import sync_fifo_pkg::*;
#(
  parameter int MAX = 8,
  localparam int PW = $clog2(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk)
    if (rst || clr) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(MAX - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised sync FIFO with count, thresholds, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW = fifo_cw(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic rd_acc, wr_acc, rd_go, wr_go;
  logic [CW-1:0] next_count;
  err_t err;
  assign rd_acc = rden && !empty;
  assign wr_acc = wren && (!full || rd_acc);
  assign rd_go = rd_acc && !clr;
  assign wr_go = wr_acc && !clr;
  assign next_count = count + CW'(wr_acc) - CW'(rd_acc);
  assign overflow = err.overflow;
  assign underflow = err.underflow;
  fifo_wrap_ctr #(.MAX(DEPTH)) u_rd_ctr (.clk(clk), .rst(rst), .clr(clr), .inc(rd_go), .ptr(rd_ptr));
  fifo_wrap_ctr #(.MAX(DEPTH)) u_wr_ctr (.clk(clk), .rst(rst), .clr(clr), .inc(wr_go), .ptr(wr_ptr));
  always_ff @(posedge clk)
    if (wr_go && !rst) mem[wr_ptr] <= i_data;
  // flags are computed from next_count so they line up with the count they describe
  always_ff @(posedge clk)
    if (rst || clr) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_THRESH == 0);
      almost_empty <= 1'b1;
      err          <= '0;
    end else begin
      count        <= next_count;
      full         <= next_count == CW'(DEPTH);
      empty        <= next_count == '0;
      almost_full  <= int'(next_count) >= AF_THRESH;
      almost_empty <= int'(next_count) <= AE_THRESH;
      err          <= err | err_t'({wren && !wr_acc, rden && !rd_acc});
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign o_data = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk)
    if (rst) o_data <= '0;
    else if (rd_go) o_data <= mem[rd_ptr];
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param at DEPTH=5
module tb_sync_fifo_param;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [7:0] i_data = '0, o_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int total = 0, bad = 0;

  sync_fifo_param #(.DEPTH(5), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(o_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_data);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_ae"}, 32'(almost_empty), 1);
    check({tag, "_af"}, 32'(almost_full), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_udf"}, 32'(underflow), 0);
    check({tag, "_data"}, 32'(o_data), 32'(exp_data));
  endtask

  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("reset", 8'h00);

    wren = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      i_data = 8'(i * 8'h11);
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_af", 32'(almost_full), 32'(i >= 3));
      check("fill_ae", 32'(almost_empty), 32'(i <= 2));
    end
    check("fill_full", 32'(full), 1);
    i_data = 8'h66;
    step();
    wren = 1'b0;
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 5);
    check("ovf_full", 32'(full), 1);

    rden = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("drain_data", 32'(o_data), FWFT ? (i < 5 ? 32'((i + 1) * 8'h11) : 0) : 32'(i * 8'h11));
      check("drain_count", 32'(count), 32'(5 - i));
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_udf_pre", 32'(underflow), 0);
    step();
    rden = 1'b0;
    check("udf_flag", 32'(underflow), 1);
    check("udf_hold", 32'(o_data), FWFT ? 0 : 32'h55);
    check("udf_ovf_sticky", 32'(overflow), 1);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check_idle("clr1", FWFT ? 8'h00 : 8'h55);

    wren = 1'b1;
    i_data = 8'hA0;
    step();
    i_data = 8'hA1;
    step();
    rden = 1'b1;
    for (int k = 0; k < 12; k++) begin
      i_data = 8'(8'hA2 + k);
      step();
      check("stream_data", 32'(o_data), FWFT ? 32'(8'hA1 + k) : 32'(8'hA0 + k));
      check("stream_count", 32'(count), 2);
    end
    rden = 1'b0;
    check("stream_ovf", 32'(overflow), 0);
    check("stream_udf", 32'(underflow), 0);

    for (int k = 0; k < 3; k++) begin
      i_data = 8'(8'hB0 + k);
      step();
    end
    check("refill_full", 32'(full), 1);
    rden = 1'b1;
    i_data = 8'hC0;
    step();
    check("fullrw_count", 32'(count), 5);
    check("fullrw_full", 32'(full), 1);
    check("fullrw_ovf", 32'(overflow), 0);
    check("fullrw_data", 32'(o_data), FWFT ? 32'hAD : 32'hAC);
    wren = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("drain2_empty", 32'(empty), 1);
    check("drain2_data", 32'(o_data), FWFT ? 0 : 32'hC0);
    wren = 1'b1;
    i_data = 8'hD0;
    step();
    rden = 1'b0;
    check("emptyrw_count", 32'(count), 1);
    check("emptyrw_udf", 32'(underflow), 1);
    check("emptyrw_empty", 32'(empty), 0);
    check("emptyrw_data", 32'(o_data), FWFT ? 32'hD0 : 32'hC0);

    for (int k = 0; k < 5; k++) begin
      i_data = 8'(8'hE0 + k);
      step();
    end
    wren = 1'b0;
    check("ovf2_flag", 32'(overflow), 1);
    rden = 1'b1;
    step();
    step();
    rden = 1'b0;
    check("q3_count", 32'(count), 3);
    clr = 1'b1;
    wren = 1'b1;
    i_data = 8'hF0;
    step();
    clr = 1'b0;
    wren = 1'b0;
    check_idle("clr2", FWFT ? 8'h00 : 8'hE0);
    step();
    check("clr2_dropped", 32'(count), 0);

    wren = 1'b1;
    i_data = 8'h12;
    step();
    i_data = 8'h34;
    rden = 1'b1;
    step();
    check("pre_rst_count", 32'(count), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wren = 1'b0;
    rden = 1'b0;
    check_idle("rst_mid", 8'h00);

    wren = 1'b1;
    i_data = 8'hA5;
    step();
    wren = 1'b0;
    check("fall_empty", 32'(empty), 0);
    check("fall_data", 32'(o_data), FWFT ? 32'hA5 : 0);
    rden = 1'b1;
    step();
    rden = 1'b0;
    check("pop_empty", 32'(empty), 1);
    check("pop_data", 32'(o_data), FWFT ? 0 : 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
